// File: rtl/oht_aes_seed_sequencer.sv
// oht_aes_seed_sequencer
// Collects compacted OHT entropy words into a 128-bit AES key block, then
// into successive plaintext blocks. It drives load/start strobes to the AES
// conditioning core. A reseed (new key) is forced every RESEED_BLOCKS blocks.
// A health-test failure zeroizes all buffers.
//
// Build option: define OHT_SEQ_DROP_CNT_EN to include the 16-bit saturating
// counter of dropped words. Without it, drop_count is tied to zero.
module oht_aes_seed_sequencer #(
  parameter int WIDTH         = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int RESEED_BLOCKS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       word_in,
  input  logic                   word_valid,
  input  logic                   health_fail,
  input  logic                   aes_busy,
  input  logic                   aes_done,
  output logic [BLOCK_WIDTH-1:0] aes_key,
  output logic                   aes_key_load,
  output logic [BLOCK_WIDTH-1:0] aes_pt,
  output logic                   aes_start,
  output logic [15:0]            drop_count,
  output logic [2:0]             seq_state
);

  localparam int WORDS = BLOCK_WIDTH / WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(RESEED_BLOCKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] RESEED_CNT = CNT_W'(RESEED_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_FILL = 3'd1,
    S_PT_FILL  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4,
    S_FLUSH    = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [CNT_W-1:0]       block_count, block_count_nxt;
  logic [BLOCK_WIDTH-1:0] key_buf, key_asm;
  logic                   accept, last_word, zeroize;
  logic                   key_load_nxt, start_nxt;

  assign seq_state = state;

  // State register plus word index and block counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      block_count <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      block_count <= block_count_nxt;
    end
  end

  // Next-state, word acceptance and strobe decode
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    block_count_nxt = block_count;
    key_load_nxt    = 1'b0;
    start_nxt       = 1'b0;
    zeroize         = 1'b0;
    key_asm         = key_buf;
    // A word arriving while health_fail forces an exit is dropped, not stored.
    accept    = word_valid && !health_fail &&
                ((state == S_KEY_FILL) || (state == S_PT_FILL));
    last_word = accept && (idx == LAST_IDX);
    key_asm[int'(idx)*WIDTH +: WIDTH] = word_in;
    if (accept) begin
      idx_nxt = last_word ? '0 : idx + IDX_W'(1);
    end
    if (health_fail) begin
      // Flush overrides any final word or in-flight aes_done.
      state_nxt       = S_FLUSH;
      idx_nxt         = '0;
      block_count_nxt = '0;
      zeroize         = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable) state_nxt = S_KEY_FILL;
        end
        S_KEY_FILL: begin
          if (last_word) begin
            key_load_nxt    = 1'b1;
            block_count_nxt = '0;
            state_nxt       = S_PT_FILL;
          end
        end
        S_PT_FILL: begin
          if (last_word) state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          if (!aes_busy) begin
            start_nxt = 1'b1;
            state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (aes_done) begin
            block_count_nxt = block_count + CNT_W'(1);
            if (!enable)                          state_nxt = S_IDLE;
            else if (block_count_nxt >= RESEED_CNT) state_nxt = S_KEY_FILL;
            else                                  state_nxt = S_PT_FILL;
          end
        end
        S_FLUSH: begin
          // A fresh key is always required after a flush.
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Key/plaintext buffers and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      key_buf      <= '0;
      aes_key      <= '0;
      aes_pt       <= '0;
      aes_key_load <= 1'b0;
      aes_start    <= 1'b0;
    end else begin
      aes_key_load <= key_load_nxt;
      aes_start    <= start_nxt;
      if (zeroize) begin
        key_buf <= '0;
        aes_key <= '0;
        aes_pt  <= '0;
      end else if (accept) begin
        if (state == S_KEY_FILL) begin
          key_buf <= key_asm;
          // aes_key only changes on a complete key, so it stays stable
          // while the next key is being gathered.
          if (last_word) aes_key <= key_asm;
        end else begin
          aes_pt[int'(idx)*WIDTH +: WIDTH] <= word_in;
        end
      end
    end
  end

`ifdef OHT_SEQ_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating count of every word strobe that was not stored
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (word_valid && !accept) begin
      drop_count <= sat_inc16(drop_count);
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_oht_aes_seed_sequencer.sv
// Table-driven bench for oht_aes_seed_sequencer (RESEED_BLOCKS=2).
module tb_oht_aes_seed_sequencer;

`ifdef OHT_SEQ_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, enable, word_valid, health_fail, aes_busy, aes_done;
  logic [31:0]  word_in;
  logic [127:0] aes_key, aes_pt;
  logic         aes_key_load, aes_start;
  logic [15:0]  drop_count;
  logic [2:0]   seq_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oht_aes_seed_sequencer #(
    .WIDTH(32), .BLOCK_WIDTH(128), .RESEED_BLOCKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .word_in(word_in),
    .word_valid(word_valid), .health_fail(health_fail),
    .aes_busy(aes_busy), .aes_done(aes_done),
    .aes_key(aes_key), .aes_key_load(aes_key_load),
    .aes_pt(aes_pt), .aes_start(aes_start),
    .drop_count(drop_count), .seq_state(seq_state)
  );

  typedef struct {
    logic         en, wv;
    logic [31:0]  w;
    logic         hf, busy, done;
    logic [2:0]   st;
    logic         load, start;
    logic [127:0] key, pt;
    logic [15:0]  drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic wv, input logic [31:0] w,
                     input logic hf, input logic busy, input logic done,
                     input logic [2:0] st, input logic load, input logic start,
                     input logic [127:0] key, input logic [127:0] pt,
                     input logic [15:0] drop);
    vec_t v;
    v.en = en; v.wv = wv; v.w = w; v.hf = hf; v.busy = busy; v.done = done;
    v.st = st; v.load = load; v.start = start; v.key = key; v.pt = pt;
    v.drop = DROP_EN ? drop : 16'd0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wv, input logic [31:0] w,
                       input logic hf, input logic busy, input logic done);
    enable = en; word_valid = wv; word_in = w;
    health_fail = hf; aes_busy = busy; aes_done = done;
  endtask

  logic [127:0] k1, k2, k3, z;
  logic [31:0]  a1, a2, a3, a4, b1, b2, b3, b4, d1, d2, d3, f1, f2, f3, f4;

  initial begin
    z  = '0;
    k1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    k2 = {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001};
    k3 = {32'hE0000004, 32'hE0000003, 32'hE0000002, 32'hE0000001};
    a1 = 32'hA0000001; a2 = 32'hA0000002; a3 = 32'hA0000003; a4 = 32'hA0000004;
    b1 = 32'hB0000001; b2 = 32'hB0000002; b3 = 32'hB0000003; b4 = 32'hB0000004;
    d1 = 32'hD0000001; d2 = 32'hD0000002; d3 = 32'hD0000003;
    f1 = 32'hF0000001; f2 = 32'hF0000002; f3 = 32'hF0000003; f4 = 32'hF0000004;

    //   en wv word          hf bsy dn  st  ld st  key pt                 drop
    // Key load
    add(1, 0, 0,            0, 0, 0,   0+1, 0, 0, z,  z,                 0);
    add(1, 1, 32'h11111111, 0, 0, 0,   1, 0, 0, z,  z,                   0);
    add(1, 1, 32'h22222222, 0, 0, 0,   1, 0, 0, z,  z,                   0);
    add(1, 1, 32'h33333333, 0, 0, 0,   1, 0, 0, z,  z,                   0);
    add(1, 1, 32'h44444444, 0, 0, 0,   2, 1, 0, k1, z,                   0);
    // First plaintext, issue held off by aes_busy for 5 cycles
    add(1, 1, a1, 0, 0, 0, 2, 0, 0, k1, {96'd0, a1},                     0);
    add(1, 1, a2, 0, 0, 0, 2, 0, 0, k1, {64'd0, a2, a1},                 0);
    add(1, 1, a3, 0, 0, 0, 2, 0, 0, k1, {32'd0, a3, a2, a1},             0);
    add(1, 1, a4, 0, 1, 0, 3, 0, 0, k1, {a4, a3, a2, a1},                0);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 0, 1, 0, 3, 0, 0, k1, {a4, a3, a2, a1},               0);
    add(1, 0, 0, 0, 0, 0, 4, 0, 1, k1, {a4, a3, a2, a1},                 0);
    // Three drops while waiting, then first aes_done -> PT_FILL
    add(1, 1, 32'h5, 0, 1, 0, 4, 0, 0, k1, {a4, a3, a2, a1},             1);
    add(1, 1, 32'h6, 0, 1, 0, 4, 0, 0, k1, {a4, a3, a2, a1},             2);
    add(1, 1, 32'h7, 0, 1, 0, 4, 0, 0, k1, {a4, a3, a2, a1},             3);
    add(1, 0, 0,     0, 0, 1, 2, 0, 0, k1, {a4, a3, a2, a1},             3);
    // Second plaintext; after its aes_done the reseed sends us to KEY_FILL
    add(1, 1, b1, 0, 0, 0, 2, 0, 0, k1, {a4, a3, a2, b1},                3);
    add(1, 1, b2, 0, 0, 0, 2, 0, 0, k1, {a4, a3, b2, b1},                3);
    add(1, 1, b3, 0, 0, 0, 2, 0, 0, k1, {a4, b3, b2, b1},                3);
    add(1, 1, b4, 0, 0, 0, 3, 0, 0, k1, {b4, b3, b2, b1},                3);
    add(1, 0, 0,  0, 0, 0, 4, 0, 1, k1, {b4, b3, b2, b1},                3);
    add(1, 0, 0,  0, 0, 1, 1, 0, 0, k1, {b4, b3, b2, b1},                3);
    add(1, 1, 32'hC0000001, 0, 0, 0, 1, 0, 0, k1, {b4, b3, b2, b1},      3);
    add(1, 1, 32'hC0000002, 0, 0, 0, 1, 0, 0, k1, {b4, b3, b2, b1},      3);
    add(1, 1, 32'hC0000003, 0, 0, 0, 1, 0, 0, k1, {b4, b3, b2, b1},      3);
    add(1, 1, 32'hC0000004, 0, 0, 0, 2, 1, 0, k2, {b4, b3, b2, b1},      3);
    // Health fail on the 4th plaintext word: flush, word dropped
    add(1, 1, d1, 0, 0, 0, 2, 0, 0, k2, {b4, b3, b2, d1},                3);
    add(1, 1, d2, 0, 0, 0, 2, 0, 0, k2, {b4, b3, d2, d1},                3);
    add(1, 1, d3, 0, 0, 0, 2, 0, 0, k2, {b4, d3, d2, d1},                3);
    add(1, 1, 32'hD0000004, 1, 0, 0, 5, 0, 0, z, z,                      4);
    add(1, 0, 0, 1, 0, 0, 5, 0, 0, z, z,                                 4);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, z, z,                                 4);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, z, z,                                 4);
    // Fresh key, then enable dropped mid plaintext fill
    add(1, 1, 32'hE0000001, 0, 0, 0, 1, 0, 0, z, z,                      4);
    add(1, 1, 32'hE0000002, 0, 0, 0, 1, 0, 0, z, z,                      4);
    add(1, 1, 32'hE0000003, 0, 0, 0, 1, 0, 0, z, z,                      4);
    add(1, 1, 32'hE0000004, 0, 0, 0, 2, 1, 0, k3, z,                     4);
    add(0, 1, f1, 0, 0, 0, 2, 0, 0, k3, {96'd0, f1},                     4);
    add(0, 1, f2, 0, 0, 0, 2, 0, 0, k3, {64'd0, f2, f1},                 4);
    add(0, 1, f3, 0, 0, 0, 2, 0, 0, k3, {32'd0, f3, f2, f1},             4);
    add(0, 1, f4, 0, 0, 0, 3, 0, 0, k3, {f4, f3, f2, f1},                4);
    add(0, 0, 0,  0, 0, 0, 4, 0, 1, k3, {f4, f3, f2, f1},                4);
    add(0, 0, 0,  0, 0, 0, 4, 0, 0, k3, {f4, f3, f2, f1},                4);
    add(0, 0, 0,  0, 0, 1, 0, 0, 0, k3, {f4, f3, f2, f1},                4);
    add(0, 1, 32'h9, 0, 0, 0, 0, 0, 0, k3, {f4, f3, f2, f1},             5);

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset seq_state", 128'(seq_state), 128'(0));
    chk("reset aes_key", aes_key, z);
    chk("reset aes_pt", aes_pt, z);
    chk("reset strobes", 128'({aes_key_load, aes_start}), 128'(0));
    chk("reset drop_count", 128'(drop_count), 128'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wv, vecs[i].w, vecs[i].hf, vecs[i].busy,
            vecs[i].done);
      tick();
      chk($sformatf("v%0d seq_state", i), 128'(seq_state), 128'(vecs[i].st));
      chk($sformatf("v%0d aes_key_load", i), 128'(aes_key_load), 128'(vecs[i].load));
      chk($sformatf("v%0d aes_start", i), 128'(aes_start), 128'(vecs[i].start));
      chk($sformatf("v%0d aes_key", i), aes_key, vecs[i].key);
      chk($sformatf("v%0d aes_pt", i), aes_pt, vecs[i].pt);
      chk($sformatf("v%0d drop_count", i), 128'(drop_count), 128'(vecs[i].drop));
    end

    // Reset mid key fill returns everything to zero in one cycle
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("midrst pre state", 128'(seq_state), 128'(1));
    drive(1, 1, 32'h12345678, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst state", 128'(seq_state), 128'(0));
    chk("midrst aes_key", aes_key, z);
    chk("midrst aes_pt", aes_pt, z);
    chk("midrst drop_count", 128'(drop_count), 128'(0));
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("postrst strobes", 128'({aes_key_load, aes_start}), 128'(0));
    chk("postrst state", 128'(seq_state), 128'(0));

    // Saturation: 70000 dropped words while idle
    drive(0, 1, 32'hFFFFFFFF, 0, 0, 0);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    word_valid = 1'b0;
    chk("drop saturation", 128'(drop_count), DROP_EN ? 128'(16'hFFFF) : 128'(0));
    tick();
    chk("drop hold", 128'(drop_count), DROP_EN ? 128'(16'hFFFF) : 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oht_aes_seed_sequencer.md
# oht_aes_seed_sequencer

Sequencer between the OHT bit compactor and the AES conditioning core. It collects compacted entropy words, assembles a 128-bit key block and then successive 128-bit plaintext blocks, and issues load/start strobes to the AES core. It forces a reseed after a programmable number of blocks and zeroizes its buffers whenever the online health test reports a failure.

## Interface
- WIDTH, 32, compactor word width; must divide BLOCK_WIDTH
- BLOCK_WIDTH, 128, AES key/plaintext width
- RESEED_BLOCKS, 16, plaintext blocks encrypted per key (≥1)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  run request
- word_in  in  WIDTH  compacted entropy word
- word_valid  in  1  single-cycle strobe; word_in valid; no backpressure exists
- health_fail  in  1  OHT failure, level-sensitive
- aes_busy  in  1  AES core busy
- aes_done  in  1  one-cycle pulse, block finished
- aes_key  out  BLOCK_WIDTH  assembled key
- aes_key_load  out  1  one-cycle pulse, aes_key valid
- aes_pt  out  BLOCK_WIDTH  assembled plaintext
- aes_start  out  1  one-cycle pulse, aes_pt valid
- drop_count  out  16  saturating count of words not accepted
- seq_state  out  3  encoded FSM state

## Operation
- WORDS = BLOCK_WIDTH/WIDTH. Word k of a block is placed at bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- States (encoding): IDLE=0, KEY_FILL=1, PT_FILL=2, ISSUE=3, WAIT=4, FLUSH=5.
- IDLE: if enable is high, go to KEY_FILL.
- KEY_FILL: accept words into the key buffer. On the WORDS-th word, pulse aes_key_load, clear block_count, and go to PT_FILL.
- PT_FILL: accept words into the plaintext buffer. On the WORDS-th word, go to ISSUE.
- ISSUE: on the first cycle with aes_busy=0, pulse aes_start and go to WAIT.
- WAIT: on aes_done, increment block_count. Then, in priority order:
  - enable=0: go to IDLE.
  - block_count reached RESEED_BLOCKS: go to KEY_FILL.
  - otherwise: go to PT_FILL.
- Words are accepted only in KEY_FILL and PT_FILL. Every other word_valid increments drop_count, saturating at 0xFFFF.
- health_fail=1 in any state moves the FSM to FLUSH (this has top priority). FLUSH zeroizes aes_key and aes_pt and clears the word index and block_count. Any in-flight aes_done is ignored.
- FLUSH: stay while health_fail=1; on health_fail=0, go to IDLE. A fresh key is always required afterwards.
- enable is sampled only in IDLE and at aes_done. Deasserting it mid-fill has no effect until the next block boundary.

## Timing
- Reset values of all outputs are 0 and seq_state=IDLE; internal buffers, the word index and block_count are also 0.
- All outputs are registered.
- The last key word accepted at cycle N gives aes_key_load high at N+1, with aes_key stable from N+1 until the next key load or FLUSH.
- The last plaintext word at cycle N gives ISSUE at N+1. aes_busy=0 sampled at cycle M in ISSUE gives aes_start high at M+1 and seq_state=WAIT at M+1. aes_pt is stable from M+1 until the next PT_FILL word.
- Minimum gap from aes_done to the next aes_start is WORDS+2 cycles.
- Simultaneous events:
  - health_fail together with a final word: FLUSH wins; no aes_key_load or aes_start pulse.
  - health_fail together with aes_done: FLUSH wins; block_count is cleared.
  - word_valid in the same cycle as a state exit is dropped and counted.
- rst mid-operation returns to the reset values within one cycle; no strobes are issued in the cycle after reset.

## Configuration
- OHT_SEQ_DROP_CNT_EN:
  - Defined: drop_count is a 16-bit saturating counter as described.
  - Undefined: counter logic is removed and drop_count is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Key load: rst, enable=1, feed 4 words 0x11111111..0x44444444 -> aes_key_load pulse with aes_key=0x44444444_33333333_22222222_11111111.
- Plaintext issue: hold aes_busy=1 for 5 cycles after PT fill -> seq_state=3 throughout, then aes_start exactly one cycle after aes_busy falls.
- Reseed: RESEED_BLOCKS=2, complete 2 aes_done cycles -> third fill enters KEY_FILL and produces aes_key_load, not aes_start.
- Drops: 3 word_valid strobes during WAIT -> drop_count=3 (0 when OHT_SEQ_DROP_CNT_EN is undefined). Force 70000 drops -> drop_count=0xFFFF.
- Health fail: assert health_fail on the 4th PT word -> no aes_start, aes_key=aes_pt=0, seq_state=5. Release -> IDLE, then KEY_FILL.
- Enable drop: deassert enable during PT_FILL -> block completes and is issued; on aes_done, seq_state=0.
